// File: rtl/row_pkt_checker.sv
// Row-packet checker: validates header/data/footer framing, header and footer
// fields and the request-ID sequence, forwarding only the data beats downstream.
module row_pkt_checker #(
  parameter int REQ_ID_WIDTH     = 32,
  parameter int BEATS_PER_PACKET = 16,
  parameter bit CHECK_SEQ        = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [511:0]            AXIS_RX_TDATA,
  input  logic                    AXIS_RX_TVALID,
  input  logic                    AXIS_RX_TLAST,
  output logic                    AXIS_RX_TREADY,
  output logic [511:0]            AXIS_TX_TDATA,
  output logic                    AXIS_TX_TVALID,
  output logic                    AXIS_TX_TLAST,
  input  logic                    AXIS_TX_TREADY,
  input  logic                    CLEAR_ERR,
  output logic [31:0]             PKT_COUNT,
  output logic [31:0]             ERR_COUNT,
  output logic [3:0]              ERR_FLAGS,
  output logic [REQ_ID_WIDTH-1:0] LAST_REQ_ID
);

  localparam int CNT_W = $clog2(BEATS_PER_PACKET + 1);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_FTR, S_RESYNC} state_e;

  state_e                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_beat_cnt, w_beat_cnt_nxt;
  logic [REQ_ID_WIDTH-1:0] r_hdr_id;
  logic                    r_seq_armed;
  logic                    r_pkt_err;
  logic [511:0]            r_tx_data;
  logic                    r_tx_valid;
  logic                    r_tx_last;
  logic [31:0]             r_pkt_count;
  logic [31:0]             r_err_count;
  logic [3:0]              r_err_flags;

  logic                    w_accept;
  logic                    w_last_beat;
  logic                    w_type_bad;
  logic [REQ_ID_WIDTH-1:0] w_rx_id;
  logic [REQ_ID_WIDTH-1:0] w_prev_inc;
  logic [3:0]              w_err;
  logic                    w_close;
  logic                    w_fwd;
  logic                    w_bad_now;

  // A data beat may only enter when the single TX register is empty or draining.
  assign AXIS_RX_TREADY = !reset &&
                          ((r_state != S_DATA) || !r_tx_valid || AXIS_TX_TREADY);
  assign w_accept    = AXIS_RX_TVALID && AXIS_RX_TREADY;
  assign w_last_beat = (r_beat_cnt == CNT_W'(1));
  assign w_type_bad  = (AXIS_RX_TDATA[7:0] != 8'h00);
  assign w_rx_id     = AXIS_RX_TDATA[8 +: REQ_ID_WIDTH];
  assign w_prev_inc  = r_hdr_id + REQ_ID_WIDTH'(1);
  assign w_bad_now   = r_pkt_err || (|w_err);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_err          = '0;
    w_close        = 1'b0;
    w_fwd          = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        S_HDR: begin
          w_err[1] = w_type_bad;
          // A clear arriving with this header suppresses its sequence check.
          w_err[3] = CHECK_SEQ && r_seq_armed && !CLEAR_ERR && (w_rx_id != w_prev_inc);
          if (AXIS_RX_TLAST) begin
            w_err[0] = 1'b1;
            w_close  = 1'b1;
          end else begin
            w_state_nxt    = S_DATA;
            w_beat_cnt_nxt = CNT_W'(BEATS_PER_PACKET);
          end
        end
        S_DATA: begin
          w_fwd = 1'b1;
          if (w_last_beat) begin
            w_state_nxt = S_FTR;
          end else if (AXIS_RX_TLAST) begin
            w_err[0]    = 1'b1;
            w_close     = 1'b1;
            w_state_nxt = S_HDR;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt - CNT_W'(1);
          end
        end
        S_FTR: begin
          w_err[1] = w_type_bad;
          w_err[2] = (w_rx_id != r_hdr_id);
          if (AXIS_RX_TLAST) begin
            w_close     = 1'b1;
            w_state_nxt = S_HDR;
          end else begin
            w_err[0]    = 1'b1;
            w_state_nxt = S_RESYNC;
          end
        end
        S_RESYNC: begin
          if (AXIS_RX_TLAST) begin
            w_close     = 1'b1;
            w_state_nxt = S_HDR;
          end
        end
        default: w_state_nxt = S_HDR;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_HDR;
      r_beat_cnt  <= '0;
      r_hdr_id    <= '0;
      r_seq_armed <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      r_pkt_count <= '0;
      r_err_count <= '0;
      r_err_flags <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;

      if (w_accept && (r_state == S_HDR)) begin
        r_hdr_id    <= w_rx_id;
        r_seq_armed <= 1'b1;
      end else if (CLEAR_ERR) begin
        r_seq_armed <= 1'b0;
      end

      // A new error in the clearing cycle survives the clear.
      r_err_flags <= (CLEAR_ERR ? 4'b0000 : r_err_flags) | w_err;

      if (w_close) begin
        r_pkt_err <= 1'b0;
        if (!w_bad_now && (r_pkt_count != 32'hFFFF_FFFF)) begin
          r_pkt_count <= r_pkt_count + 32'd1;
        end
      end else begin
        r_pkt_err <= w_bad_now;
      end

      if (CLEAR_ERR) begin
        r_err_count <= (w_close && w_bad_now) ? 32'd1 : 32'd0;
      end else if (w_close && w_bad_now && (r_err_count != 32'hFFFF_FFFF)) begin
        r_err_count <= r_err_count + 32'd1;
      end

      if (w_fwd) begin
        r_tx_data  <= AXIS_RX_TDATA;
        r_tx_valid <= 1'b1;
        r_tx_last  <= w_last_beat || AXIS_RX_TLAST;
      end else if (AXIS_TX_TREADY) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign AXIS_TX_TDATA  = r_tx_data;
  assign AXIS_TX_TVALID = r_tx_valid;
  assign AXIS_TX_TLAST  = r_tx_last;
  assign PKT_COUNT      = r_pkt_count;
  assign ERR_COUNT      = r_err_count;
  assign ERR_FLAGS      = r_err_flags;
  assign LAST_REQ_ID    = r_hdr_id;

endmodule
